// File: rtl/vec_pipe_pkg.sv
// Shared types for the vector MEM->WB stage: lane data vector, writeback control, stage states.
package vec_pipe_pkg;

    localparam int VP_LANES = 16;
    localparam int VP_WIDTH = 32;
    localparam int VP_WA_W  = 4;
    localparam int VP_CNT_W = 16;

    typedef logic [VP_LANES-1:0][VP_WIDTH-1:0] lane_vec_t;

    typedef struct packed {
        logic               pcsrc;
        logic               regwrite;
        logic               memtoreg;
        logic [VP_WA_W-1:0] wa3;
        logic               v_s;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/vec_beat_reg.sv
// One-beat holding register: per-lane masked data load plus full control load.
// Latency: 1 cycle from load to q.
// Backpressure: none; the parent decides when to assert load.
module vec_beat_reg
    import vec_pipe_pkg::*;
#(
    parameter int LANES  = VP_LANES,
    parameter int WIDTH  = VP_WIDTH,
    parameter int CTRL_W = VP_WA_W + 4
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         load,
    input  logic [LANES-1:0]             lane_mask,
    input  logic [LANES-1:0][WIDTH-1:0]  alu_d,
    input  logic [LANES-1:0][WIDTH-1:0]  rd_d,
    input  logic [CTRL_W-1:0]            ctrl_d,
    output logic [LANES-1:0][WIDTH-1:0]  alu_q,
    output logic [LANES-1:0][WIDTH-1:0]  rd_q,
    output logic [CTRL_W-1:0]            ctrl_q
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_q  <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
        end else if (load) begin
            ctrl_q <= ctrl_d;
            for (int i = 0; i < LANES; i++) begin
                if (lane_mask[i]) begin
                    alu_q[i] <= alu_d[i];
                    rd_q[i]  <= rd_d[i];
                end
            end
        end
    end

endmodule

// File: rtl/vec_pipe_stage_mw.sv
// Elastic MEM->WB stage with lane-masked data, flush and saturating stall counter.
// Latency: 1 cycle accept to out_valid; VEC_PIPE_SKID_EN adds a skid beat.
// Backpressure: in_ready = !out_valid || out_ready, or registered (state != TWO) with skid.
module vec_pipe_stage_mw
    import vec_pipe_pkg::*;
#(
    parameter int LANES = VP_LANES,
    parameter int WIDTH = VP_WIDTH,
    parameter int WA_W  = VP_WA_W,
    parameter int CNT_W = VP_CNT_W
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    input  logic [LANES-1:0]             lane_mask_i,
    input  logic [LANES-1:0][WIDTH-1:0]  ALUOut_i,
    input  logic [LANES-1:0][WIDTH-1:0]  ReadData_i,
    input  logic                         PCSrc_i,
    input  logic                         RegWrite_i,
    input  logic                         MemtoReg_i,
    input  logic                         v_s_i,
    input  logic [WA_W-1:0]              WA3_i,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES-1:0][WIDTH-1:0]  ALUOut_o,
    output logic [LANES-1:0][WIDTH-1:0]  ReadData_o,
    output logic                         PCSrc_o,
    output logic                         RegWrite_o,
    output logic                         MemtoReg_o,
    output logic                         v_s_o,
    output logic [WA_W-1:0]              WA3_o,
    output logic [CNT_W-1:0]             stall_cnt,
    input  logic                         stall_clr
);

    localparam int CTRL_W = WA_W + 4;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    stage_state_e                 state_q, state_d;
    logic                         acc, out_fire, main_load;
    logic [LANES-1:0]             main_mask;
    logic [LANES-1:0][WIDTH-1:0]  main_alu_d, main_rd_d;
    logic [CTRL_W-1:0]            ctrl_in, main_ctrl_d, main_ctrl_q;
    logic [CNT_W-1:0]             cnt_q;

    assign ctrl_in  = {PCSrc_i, RegWrite_i, MemtoReg_i, v_s_i, WA3_i};
    assign acc      = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= EMPTY;
        else        state_q <= state_d;
    end

`ifdef VEC_PIPE_SKID_EN
    logic                         skid_load, from_skid, in_rdy_q;
    logic [LANES-1:0]             skid_mask_q;
    logic [LANES-1:0][WIDTH-1:0]  skid_alu_q, skid_rd_q;
    logic [CTRL_W-1:0]            skid_ctrl_q;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (acc) state_d = ONE;
                ONE:     if (acc && !out_fire) state_d = TWO;
                         else if (!acc && out_fire) state_d = EMPTY;
                TWO:     if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Skid keeps the full beat; its mask is replayed when it moves to main.
    always_comb begin
        out_valid   = (state_q != EMPTY);
        from_skid   = (state_q == TWO);
        skid_load   = !flush && acc && (state_q == ONE) && !out_ready;
        main_load   = !flush && (from_skid ? out_ready
                                           : (acc && ((state_q == EMPTY) || out_ready)));
        main_mask   = from_skid ? skid_mask_q : lane_mask_i;
        main_alu_d  = from_skid ? skid_alu_q  : ALUOut_i;
        main_rd_d   = from_skid ? skid_rd_q   : ReadData_i;
        main_ctrl_d = from_skid ? skid_ctrl_q : ctrl_in;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_rdy_q    <= 1'b1;
            skid_mask_q <= '0;
        end else begin
            in_rdy_q <= (state_d != TWO);
            if (skid_load) skid_mask_q <= lane_mask_i;
        end
    end

    assign in_ready = in_rdy_q;

    vec_beat_reg #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_skid (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (skid_load),
        .lane_mask ({LANES{1'b1}}),
        .alu_d     (ALUOut_i),
        .rd_d      (ReadData_i),
        .ctrl_d    (ctrl_in),
        .alu_q     (skid_alu_q),
        .rd_q      (skid_rd_q),
        .ctrl_q    (skid_ctrl_q)
    );
`else
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (acc) state_d = ONE;
                ONE:     if (!acc && out_fire) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // A flushed handshake completes upstream but never reaches the register.
    always_comb begin
        out_valid   = (state_q == ONE);
        in_ready    = (state_q != ONE) || out_ready;
        main_load   = in_valid && in_ready && !flush;
        main_mask   = lane_mask_i;
        main_alu_d  = ALUOut_i;
        main_rd_d   = ReadData_i;
        main_ctrl_d = ctrl_in;
    end
`endif

    vec_beat_reg #(.LANES(LANES), .WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_main (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (main_load),
        .lane_mask (main_mask),
        .alu_d     (main_alu_d),
        .rd_d      (main_rd_d),
        .ctrl_d    (main_ctrl_d),
        .alu_q     (ALUOut_o),
        .rd_q      (ReadData_o),
        .ctrl_q    (main_ctrl_q)
    );

    // Bubbles must never write the register file or redirect the PC.
    assign PCSrc_o    = main_ctrl_q[CTRL_W-1] & out_valid;
    assign RegWrite_o = main_ctrl_q[CTRL_W-2] & out_valid;
    assign MemtoReg_o = main_ctrl_q[CTRL_W-3];
    assign v_s_o      = main_ctrl_q[WA_W];
    assign WA3_o      = main_ctrl_q[WA_W-1:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                          cnt_q <= '0;
        else if (stall_clr)                                  cnt_q <= '0;
        else if (out_valid && !out_ready && (cnt_q != '1))  cnt_q <= cnt_q + CNT_ONE;
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_vec_pipe_stage_mw.sv
// Bench for vec_pipe_stage_mw: directed table, corner sequences, random traffic vs queue model.
module tb_vec_pipe_stage_mw;
    import vec_pipe_pkg::*;

    localparam int L = VP_LANES;
    localparam int W = VP_WIDTH;
`ifdef VEC_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic            in_valid, flush, out_ready, stall_clr;
    logic [L-1:0]    lane_mask_i;
    lane_vec_t       ALUOut_i, ReadData_i;
    logic            PCSrc_i, RegWrite_i, MemtoReg_i, v_s_i;
    logic [3:0]      WA3_i;

    logic            in_ready, out_valid, PCSrc_o, RegWrite_o, MemtoReg_o, v_s_o;
    lane_vec_t       ALUOut_o, ReadData_o;
    logic [3:0]      WA3_o;
    logic [15:0]     stall_cnt;

    logic            s_in_ready, s_out_valid, s_pc, s_rw, s_m2r, s_vs;
    lane_vec_t       s_alu, s_rd;
    logic [3:0]      s_wa;
    logic [3:0]      s_stall_cnt;

    vec_pipe_stage_mw dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .lane_mask_i(lane_mask_i), .ALUOut_i(ALUOut_i), .ReadData_i(ReadData_i),
        .PCSrc_i(PCSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .v_s_i(v_s_i),
        .WA3_i(WA3_i), .out_valid(out_valid), .out_ready(out_ready), .ALUOut_o(ALUOut_o),
        .ReadData_o(ReadData_o), .PCSrc_o(PCSrc_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .v_s_o(v_s_o), .WA3_o(WA3_o), .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    vec_pipe_stage_mw #(.CNT_W(4)) dut_s (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(s_in_ready), .flush(flush),
        .lane_mask_i(lane_mask_i), .ALUOut_i(ALUOut_i), .ReadData_i(ReadData_i),
        .PCSrc_i(PCSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .v_s_i(v_s_i),
        .WA3_i(WA3_i), .out_valid(s_out_valid), .out_ready(out_ready), .ALUOut_o(s_alu),
        .ReadData_o(s_rd), .PCSrc_o(s_pc), .RegWrite_o(s_rw), .MemtoReg_o(s_m2r),
        .v_s_o(s_vs), .WA3_o(s_wa), .stall_cnt(s_stall_cnt), .stall_clr(stall_clr)
    );

    typedef struct {
        lane_vec_t    alu;
        lane_vec_t    rd;
        logic [L-1:0] mask;
        wb_ctrl_t     ctrl;
    } beat_t;

    typedef struct {
        logic        vld;
        logic        fl;
        logic [15:0] mask;
        logic [31:0] fill;
        logic [3:0]  wa;
        logic        rw;
        logic        e_vld;
        logic        e_rw;
        logic [3:0]  e_wa;
        logic [31:0] e_l0;
        logic [31:0] e_l15;
    } vec_t;

    // Reference model: the stage is a FIFO of beats; the visible data register
    // takes the masked lanes of whichever beat becomes the head.
    beat_t        q[$];
    lane_vec_t    vis_alu, vis_rd;
    wb_ctrl_t     m_ctrl;
    int unsigned  cnt_a, cnt_b;
    logic [3:0]   acc_log[$], dep_log[$];
    int           checks = 0;
    int           failures = 0;

    task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready(input logic ordy);
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    function automatic beat_t zero_beat();
        beat_t b;
        b.alu = '0; b.rd = '0; b.mask = '0; b.ctrl = '0;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        logic [31:0] r;
        for (int i = 0; i < L; i++) begin
            b.alu[i] = $urandom;
            b.rd[i]  = $urandom;
        end
        r = $urandom;
        b.mask = r[15:0];
        b.ctrl = r[23:16];
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        vis_alu = '0; vis_rd = '0; m_ctrl = '0; cnt_a = 0; cnt_b = 0;
    endtask

    task automatic model_edge(input logic vld, input logic ordy, input logic fl,
                              input logic clr, input beat_t b);
        bit fin, fout, was_empty;
        fin  = vld && m_ready(ordy);
        fout = (q.size() > 0) && ordy;
        if (clr) begin
            cnt_a = 0; cnt_b = 0;
        end else if (q.size() > 0 && !ordy) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 15)    cnt_b++;
        end
        if (fl) begin
            q.delete();
        end else begin
            was_empty = (q.size() == 0);
            if (fout) void'(q.pop_front());
            if (fin)  q.push_back(b);
            if ((fout || was_empty) && q.size() > 0) begin
                for (int i = 0; i < L; i++)
                    if (q[0].mask[i]) begin
                        vis_alu[i] = q[0].alu[i];
                        vis_rd[i]  = q[0].rd[i];
                    end
                m_ctrl = q[0].ctrl;
            end
        end
    endtask

    task automatic check_outputs();
        logic v;
        v = (q.size() > 0);
        chk("out_valid", out_valid, v);
        chk("ALUOut_o", ALUOut_o, vis_alu);
        chk("ReadData_o", ReadData_o, vis_rd);
        chk("PCSrc_o", PCSrc_o, m_ctrl.pcsrc & v);
        chk("RegWrite_o", RegWrite_o, m_ctrl.regwrite & v);
        chk("MemtoReg_o", MemtoReg_o, m_ctrl.memtoreg);
        chk("v_s_o", v_s_o, m_ctrl.v_s);
        chk("WA3_o", WA3_o, m_ctrl.wa3);
        chk("stall_cnt", stall_cnt, cnt_a);
        chk("s_out_valid", s_out_valid, v);
        chk("s_ALUOut_o", s_alu, vis_alu);
        chk("s_ReadData_o", s_rd, vis_rd);
        chk("s_ctrl", {s_pc, s_rw, s_m2r, s_vs, s_wa},
            {m_ctrl.pcsrc & v, m_ctrl.regwrite & v, m_ctrl.memtoreg, m_ctrl.v_s, m_ctrl.wa3});
        chk("s_stall_cnt", s_stall_cnt, cnt_b);
    endtask

    task automatic cycle(input logic vld, input logic ordy, input logic fl,
                         input logic clr, input beat_t b);
        in_valid = vld; out_ready = ordy; flush = fl; stall_clr = clr;
        lane_mask_i = b.mask; ALUOut_i = b.alu; ReadData_i = b.rd;
        PCSrc_i = b.ctrl.pcsrc; RegWrite_i = b.ctrl.regwrite; MemtoReg_i = b.ctrl.memtoreg;
        v_s_i = b.ctrl.v_s; WA3_i = b.ctrl.wa3;
        #1;
        chk("in_ready", in_ready, m_ready(ordy));
        chk("s_in_ready", s_in_ready, m_ready(ordy));
        if (vld && in_ready && !fl) acc_log.push_back(b.ctrl.wa3);
        if (out_valid && ordy)      dep_log.push_back(WA3_o);
        @(posedge CLK);
        model_edge(vld, ordy, fl, clr, b);
        @(negedge CLK);
        check_outputs();
    endtask

    // Reset lands between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        RST_N = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst RegWrite_o", RegWrite_o, 1'b0);
        chk("rst PCSrc_o", PCSrc_o, 1'b0);
        chk("rst ALUOut_o", ALUOut_o, '0);
        chk("rst ReadData_o", ReadData_o, '0);
        chk("rst WA3_o", WA3_o, 4'd0);
        chk("rst stall_cnt", stall_cnt, 16'd0);
        model_reset();
        acc_log.delete(); dep_log.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        chk("rst in_ready", in_ready, 1'b1);
    endtask

    vec_t  tbl[6];
    beat_t b, idle;
    lane_vec_t exp_v;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'hFFFF, 32'hAAAA_AAAA, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        tbl[1] = '{1'b1, 1'b0, 16'h00FF, 32'h5555_5555, 4'd7, 1'b1, 1'b1, 1'b1, 4'd7, 32'h5555_5555, 32'hAAAA_AAAA};
        tbl[2] = '{1'b0, 1'b0, 16'h0000, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 32'h5555_5555, 32'hAAAA_AAAA};
        tbl[3] = '{1'b1, 1'b1, 16'hFFFF, 32'h1234_5678, 4'd9, 1'b1, 1'b0, 1'b0, 4'd7, 32'h5555_5555, 32'hAAAA_AAAA};
        tbl[4] = '{1'b1, 1'b0, 16'h8000, 32'h0000_0001, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 32'h5555_5555, 32'h0000_0001};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 32'h0000_0000, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 32'h5555_5555, 32'h0000_0001};

        idle = zero_beat();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        lane_mask_i = '0; ALUOut_i = '0; ReadData_i = '0;
        PCSrc_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; v_s_i = 1'b0; WA3_i = '0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        chk("reset in_ready", in_ready, 1'b1);
        check_outputs();

        // Single beat, lane i carries i.
        b = zero_beat();
        for (int i = 0; i < L; i++) begin
            b.alu[i] = i;
            exp_v[i] = i;
            b.rd[i]  = $urandom;
        end
        b.mask = '1; b.ctrl.regwrite = 1'b1; b.ctrl.wa3 = 4'd5;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, b);
        chk("t1 out_valid", out_valid, 1'b1);
        chk("t1 lane index", ALUOut_o, exp_v);
        chk("t1 RegWrite_o", RegWrite_o, 1'b1);
        chk("t1 WA3_o", WA3_o, 4'd5);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle);
        chk("t1 single cycle", out_valid, 1'b0);

        for (int r = 0; r < 6; r++) begin
            b = zero_beat();
            for (int i = 0; i < L; i++) begin
                b.alu[i] = tbl[r].fill;
                b.rd[i]  = ~tbl[r].fill;
            end
            b.mask = tbl[r].mask; b.ctrl.wa3 = tbl[r].wa; b.ctrl.regwrite = tbl[r].rw;
            cycle(tbl[r].vld, 1'b1, tbl[r].fl, 1'b0, b);
            chk($sformatf("tbl%0d out_valid", r), out_valid, tbl[r].e_vld);
            chk($sformatf("tbl%0d RegWrite_o", r), RegWrite_o, tbl[r].e_rw);
            chk($sformatf("tbl%0d WA3_o", r), WA3_o, tbl[r].e_wa);
            chk($sformatf("tbl%0d lane0", r), ALUOut_o[0], tbl[r].e_l0);
            chk($sformatf("tbl%0d lane15", r), ALUOut_o[15], tbl[r].e_l15);
        end

        // Backpressure: three beats offered while the consumer stalls for 10 cycles.
        async_reset();
        for (int c = 0; c < 11; c++) begin
            b = rand_beat();
            b.ctrl.wa3 = 4'(10 + acc_log.size());
            cycle(acc_log.size() < 3, 1'b0, 1'b0, 1'b0, b);
        end
        chk("bp accepted", acc_log.size(), SKID ? 2 : 1);
        chk("bp stall_cnt", stall_cnt, 16'd10);
        chk("bp in_ready", in_ready, 1'b0);
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0, idle);
        chk("bp drained", dep_log.size(), acc_log.size());
        for (int i = 0; i < acc_log.size() && i < dep_log.size(); i++)
            chk($sformatf("bp order %0d", i), dep_log[i], acc_log[i]);

        // Flush with a beat held and another being offered.
        async_reset();
        b = rand_beat(); b.ctrl.regwrite = 1'b1; b.ctrl.wa3 = 4'd1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, b);
        b = rand_beat(); b.ctrl.regwrite = 1'b1; b.ctrl.wa3 = 4'd2;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, b);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush RegWrite_o", RegWrite_o, 1'b0);
        dep_log.delete();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle);
        chk("flush beat never appears", dep_log.size(), 0);

        // Saturation of the narrow counter, then clear while still stalling.
        async_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
        for (int c = 0; c < 20; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0, idle);
        chk("sat wide cnt", stall_cnt, 16'd20);
        chk("sat narrow cnt", s_stall_cnt, 4'd15);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, idle);
        chk("clr wide cnt", stall_cnt, 16'd0);
        chk("clr narrow cnt", s_stall_cnt, 4'd0);

        // Asynchronous reset with the stage full (TWO in the skid build).
        async_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
        cycle(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
        async_reset();
        check_outputs();

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++)
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 29) == 0,
                  ($urandom % 37) == 0, rand_beat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_pipe_stage_mw.md
# vec_pipe_stage_mw

Parametrised elastic MEM→WB pipeline stage for the vector core, replacing the fixed 16×32 always-load register. It carries per-lane ALU results and load data plus writeback control across one clock, with a valid/ready handshake, flush, and per-lane load masking. A saturating stall counter supports performance debug. An optional skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `LANES`, 16, number of vector lanes
- `WIDTH`, 32, bits per lane
- `WA_W`, 4, writeback register address width
- `CNT_W`, 16, stall counter width
- Clocking is fixed: one clock; reset is asynchronous and active-low.
- `CLK`  in  1  clock, rising edge
- `RST_N`  in  1  asynchronous active-low reset
- `in_valid`  in  1  upstream (MEM) beat valid
- `in_ready`  out  1  stage accepts beat this cycle
- `flush`  in  1  discard all held beats
- `lane_mask_i`  in  LANES  per-lane data load enable
- `ALUOut_i`, `ReadData_i`  in  LANES×WIDTH each  lane data from MEM
- `PCSrc_i`, `RegWrite_i`, `MemtoReg_i`, `v_s_i`  in  1 each  control
- `WA3_i`  in  WA_W  destination register
- `out_valid`  out  1  WB beat valid
- `out_ready`  in  1  WB consumes beat
- `ALUOut_o`, `ReadData_o`  out  LANES×WIDTH each
- `PCSrc_o`, `RegWrite_o`, `MemtoReg_o`, `v_s_o`  out  1 each
- `WA3_o`  out  WA_W
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`
- `stall_clr`  in  1  synchronous clear of `stall_cnt`

## Operation
- A beat transfers in on `in_valid && in_ready` and out on `out_valid && out_ready`.
- On accept, lane i of the data registers loads only when `lane_mask_i[i]=1`. Masked lanes hold their previous value.
- Control fields and `WA3` always load on accept.
- `PCSrc_o` and `RegWrite_o` are forced to 0 whenever `out_valid=0`. A bubble never writes the register file or redirects the PC.
- `flush=1` clears all valid bits at the next edge.
  - An input handshake in the same cycle completes but its beat is dropped. Flush wins.
  - Data registers are not cleared.
- Stall counter:
  - increments each cycle with `out_valid && !out_ready`;
  - saturates at 2^CNT_W−1;
  - `stall_clr` forces 0 and wins over increment;
  - flush does not touch it.
- State machine:
  - EMPTY (no beat)
  - ONE (main holds beat)
  - TWO (main + skid; skid build only)

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Reset: all outputs are 0, except `in_ready=1`. State is EMPTY and `stall_cnt=0`.
- Non-skid build:
  - `in_ready = !out_valid || out_ready` (combinational path from `out_ready`).
  - Throughput is 1 beat/cycle.
  - Simultaneous in and out in ONE replaces the main beat.
- Skid build: `in_ready` is registered, `= (state != TWO)`. Transitions:
  - EMPTY + in → ONE.
  - ONE + in + !out → TWO; beat captured into skid.
  - ONE + in + out → ONE; main replaced.
  - ONE + out → EMPTY.
  - TWO + out → ONE; skid moves to main, applying the skid's stored lane mask.
- Any state + flush → EMPTY.
- Reset asserted mid-operation asynchronously returns to the reset values. No beat survives.

## Configuration
- `VEC_PIPE_SKID_EN` defined: skid register plus TWO state, registered `in_ready`, zero-bubble throughput.
- `VEC_PIPE_SKID_EN` undefined: single register, combinational `in_ready`, states EMPTY/ONE only. Ports are identical in both builds.

## Structure
- Package `vec_pipe_pkg` holds:
  - `lane_vec_t` (LANES×WIDTH packed array);
  - `wb_ctrl_t` struct (PCSrc, RegWrite, MemtoReg, WA3, v_s);
  - `stage_state_e` enum (EMPTY, ONE, TWO).
- Sub-module `vec_beat_reg` is a one-beat holding register: masked lane load, control load, and asynchronous active-low reset to 0. It is instantiated as main, and as skid when `VEC_PIPE_SKID_EN` is defined.

## Test plan
- Reset, then a single beat: ALUOut lanes = lane index, RegWrite=1, WA3=5, mask all ones. Out appears next cycle with matching values; `out_valid` is high for 1 cycle with `out_ready=1`.
- Mask test: load lanes with 0xAAAA_AAAA, then a second beat of 0x5555_5555 with mask 0x00FF. Lanes 0–7 read 0x5555_5555 and lanes 8–15 read 0xAAAA_AAAA.
- Backpressure: hold `out_ready=0` for 10 cycles with 3 beats offered.
  - Skid build: 2 accepted, `in_ready=0` on the third.
  - Non-skid build: 1 accepted.
  - Either build: `stall_cnt=10`, and order is preserved on release.
- Flush with a beat held and `in_valid=1`: next cycle `out_valid=0` and `RegWrite_o=0`; the in-flight beat never appears.
- Saturation: with CNT_W=4, stall for 20 cycles. `stall_cnt=15`; `stall_clr` returns it to 0.
- Asynchronous reset mid-backpressure (TWO state): outputs are 0 immediately and `in_ready=1` after release.
